branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Branch/jump resolution stage that consumes the ALU status flags (`Zerof`, `Sf`, `Vf`, `C`) produced by a subtract in EX and turns them into a registered PC redirect plus pipeline flush controls. It sits between the EX stage and the fetch PC mux. Every taken control transfer produces exactly one redirect cycle, and the wrong-path instruction in EX during that cycle is ignored.

## Interface
- `N`, 32, datapath/PC width
- `clk` input 1 — rising-edge clock
- `rst` input 1 — asynchronous, active-low reset
- `valid_ex` input 1 — EX holds a real instruction
- `stall` input 1 — pipeline stall; EX contents held, no evaluation
- `branch` input 1 — conditional branch in EX
- `jal` input 1 — JAL in EX
- `jalr` input 1 — JALR in EX
- `funct3` input 3 — branch condition code
- `Zerof`, `Sf`, `Vf`, `C` input 1 each — ALU flags from `A - B`
- `pc_ex` input N — PC of EX instruction
- `imm_ex` input N — sign-extended immediate
- `alu_out` input N — ALU result (`rs1 + imm` for JALR)
- `redirect` output 1 — PC mux selects `target`
- `target` output N — redirect PC
- `flush_ifid` output 1 — squash IF/ID
- `flush_idex` output 1 — squash ID/EX
- `misalign` output 1 — pulse: target bit 1 set
- `illegal_br` output 1 — pulse: reserved `funct3` on a branch
- `br_total`, `br_taken` output 32 each — statistics counters

## Operation
- The unit is a two-state FSM, IDLE and REDIRECT. Reset state is IDLE.
- **Evaluation:** performed in IDLE when `valid_ex & !stall & (branch|jal|jalr)`. Priority is `jalr` > `jal` > `branch`.
- **Branch conditions** (take = condition true):
  - `000` BEQ: `Zerof`
  - `001` BNE: `!Zerof`
  - `100` BLT: `Sf^Vf`
  - `101` BGE: `!(Sf^Vf)`
  - `110` BLTU: `!C`
  - `111` BGEU: `C`
  - `C=1` means no borrow, i.e. A ≥ B unsigned.
- **Reserved `funct3`** (`010`, `011`): the branch is not taken and `illegal_br` pulses for one cycle.
- **Target computation:**
  - branch/JAL: `pc_ex + imm_ex`, modulo 2^N with wrap allowed.
  - JALR: `alu_out & ~1`.
  - If `target[1]` is set, `misalign` pulses alongside `redirect`; the redirect still occurs.
- **Taken transfer:** register `target`, go to REDIRECT.
- **Not-taken transfer:** stay in IDLE; no outputs assert.
- **In REDIRECT:**
  - `redirect`, `flush_ifid` and `flush_idex` are all 1.
  - `valid_ex` and the decode inputs are ignored, because the EX instruction is wrong-path.
  - The FSM returns to IDLE unconditionally after one cycle, even if `stall=1`. A redirect overrides a stall.
- **Mid-operation reset:** `rst` low in any state forces IDLE immediately.
- **Reset values:** all outputs 0, `target`=0, counters 0.

## Timing
- Latency: the flags are sampled at edge k; `redirect`, `target` and the flushes are high for exactly the cycle after edge k, and drop at edge k+1.
- The pulses (`misalign`, `illegal_br`) are registered and coincide with the cycle following evaluation.
- Back-to-back: a taken branch cannot be followed by another evaluation in the REDIRECT cycle. The earliest next evaluation is the cycle after REDIRECT.
- `stall` high in IDLE: no evaluation and no state change. The decision is made on the first unstalled cycle.
- Outputs depend only on registers; there are no combinational paths from inputs to outputs.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `br_total` increments on every evaluated conditional branch, including reserved `funct3`.
  - `br_taken` increments on every taken conditional branch.
  - JAL/JALR are not counted.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- `BRANCH_STATS_EN` undefined: the counter registers are not built, and `br_total`/`br_taken` are tied to 0. The ports remain.

## Test plan
- BEQ, `Zerof=1`, `pc_ex`=0x100, `imm_ex`=0x20: next cycle `redirect`=1, `target`=0x120, both flushes 1 for one cycle only. Same with `Zerof=0`: no redirect.
- BLTU with `C=0` → taken; BGEU with `C=0` → not taken; BLT with `Sf=1`, `Vf=1` → not taken; BGE with `Sf=0`, `Vf=1` → not taken.
- JALR with `alu_out`=0x203: `target`=0x202, `misalign`=1. JAL with `pc_ex`=0xFFFFFFFC, `imm_ex`=8: `target`=0x4.
- Taken BNE followed by a valid BEQ (`Zerof=1`) in the REDIRECT cycle: the second branch is ignored and `redirect` lasts exactly one cycle. With `stall=1` during the first branch's evaluation cycle: no redirect until `stall` drops.
- `funct3`=`010` branch: `illegal_br` pulses, no redirect. Reset asserted in the REDIRECT cycle: all outputs 0 asynchronously, IDLE after release.
- With `BRANCH_STATS_EN`: 3 taken and 2 not-taken branches plus one JAL give `br_total`=5, `br_taken`=3. Preloading `br_total`=0xFFFFFFFF and issuing one branch wraps it to 0. Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution: ALU flags in EX become a one-cycle registered
// PC redirect with flushes. Optional counters under BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_ex,
    input  logic         stall,
    input  logic         branch,
    input  logic         jal,
    input  logic         jalr,
    input  logic [2:0]   funct3,
    input  logic         Zerof,
    input  logic         Sf,
    input  logic         Vf,
    input  logic         C,
    input  logic [N-1:0] pc_ex,
    input  logic [N-1:0] imm_ex,
    input  logic [N-1:0] alu_out,
    output logic         redirect,
    output logic [N-1:0] target,
    output logic         flush_ifid,
    output logic         flush_idex,
    output logic         misalign,
    output logic         illegal_br,
    output logic [31:0]  br_total,
    output logic [31:0]  br_taken
);

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t        state;
    logic          eval;
    logic          cond;
    logic          rsvd;
    logic          take;
    logic          is_br;
    logic [N-1:0]  tgt;

    assign eval = (state == IDLE) & valid_ex & ~stall
                & (branch | jal | jalr);

    // Branch condition from the subtract flags; 010/011 are reserved
    always_comb begin
        cond = 1'b0;
        rsvd = 1'b0;
        unique case (funct3)
            3'b000:  cond = Zerof;
            3'b001:  cond = ~Zerof;
            3'b100:  cond = Sf ^ Vf;
            3'b101:  cond = ~(Sf ^ Vf);
            3'b110:  cond = ~C;
            3'b111:  cond = C;
            default: rsvd = 1'b1;
        endcase
    end

    // Transfer kind with jalr > jal > branch, plus the candidate target
    always_comb begin
        take  = 1'b0;
        is_br = 1'b0;
        tgt   = pc_ex + imm_ex;
        unique case (1'b1)
            jalr: begin
                take = 1'b1;
                tgt  = alu_out & ~{{(N-1){1'b0}}, 1'b1};
            end
            jal & ~jalr: begin
                take = 1'b1;
            end
            branch & ~jal & ~jalr: begin
                is_br = 1'b1;
                take  = cond;
            end
            default: begin
                take = 1'b0;
            end
        endcase
    end

    // IDLE/REDIRECT FSM; all outputs registered, redirect lasts one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            redirect   <= 1'b0;
            flush_ifid <= 1'b0;
            flush_idex <= 1'b0;
            misalign   <= 1'b0;
            illegal_br <= 1'b0;
            target     <= '0;
        end else begin
            redirect   <= 1'b0;
            flush_ifid <= 1'b0;
            flush_idex <= 1'b0;
            misalign   <= 1'b0;
            illegal_br <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (eval) begin
                        illegal_br <= is_br & rsvd;
                        if (take) begin
                            state      <= REDIRECT;
                            target     <= tgt;
                            redirect   <= 1'b1;
                            flush_ifid <= 1'b1;
                            flush_idex <= 1'b1;
                            misalign   <= tgt[1];
                        end
                    end
                end
                REDIRECT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] tot_q;
    logic [31:0] tkn_q;

    // Count evaluated conditional branches and the taken subset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tot_q <= '0;
            tkn_q <= '0;
        end else if (eval & is_br) begin
            tot_q <= tot_q + 32'd1;
            if (take) begin
                tkn_q <= tkn_q + 32'd1;
            end
        end
    end

    assign br_total = tot_q;
    assign br_taken = tkn_q;
`else
    assign br_total = '0;
    assign br_taken = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed plan steps
// followed by randomized transfers against a compare-based model.
module tb_branch_resolve_unit;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         valid_ex;
    logic         stall;
    logic         branch;
    logic         jal;
    logic         jalr;
    logic [2:0]   funct3;
    logic         Zerof;
    logic         Sf;
    logic         Vf;
    logic         C;
    logic [N-1:0] pc_ex;
    logic [N-1:0] imm_ex;
    logic [N-1:0] alu_out;
    logic         redirect;
    logic [N-1:0] target;
    logic         flush_ifid;
    logic         flush_idex;
    logic         misalign;
    logic         illegal_br;
    logic [31:0]  br_total;
    logic [31:0]  br_taken;

    int vectors = 0;
    int miscompares = 0;

    logic        m_redir;
    logic [31:0] m_tot;
    logic [31:0] m_tkn;

    branch_resolve_unit #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_ex   (valid_ex),
        .stall      (stall),
        .branch     (branch),
        .jal        (jal),
        .jalr       (jalr),
        .funct3     (funct3),
        .Zerof      (Zerof),
        .Sf         (Sf),
        .Vf         (Vf),
        .C          (C),
        .pc_ex      (pc_ex),
        .imm_ex     (imm_ex),
        .alu_out    (alu_out),
        .redirect   (redirect),
        .target     (target),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .misalign   (misalign),
        .illegal_br (illegal_br),
        .br_total   (br_total),
        .br_taken   (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_tot();
`ifdef BRANCH_STATS_EN
        return m_tot;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_tkn();
`ifdef BRANCH_STATS_EN
        return m_tkn;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] ctl();
        return {27'd0, redirect, flush_ifid, flush_idex, misalign, illegal_br};
    endfunction

    // Reference: branch outcome straight from the operand comparison
    function automatic logic br_ref(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic flags_from(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
        Zerof = (s[31:0] == 32'd0);
        Sf    = s[31];
        C     = s[32];
        Vf    = (a[31] ^ b[31]) & (a[31] ^ s[31]);
    endtask

    task automatic idle_in();
        valid_ex = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        jal      = 1'b0;
        jalr     = 1'b0;
        funct3   = 3'd0;
        Zerof    = 1'b0;
        Sf       = 1'b0;
        Vf       = 1'b0;
        C        = 1'b0;
        pc_ex    = '0;
        imm_ex   = '0;
        alu_out  = '0;
    endtask

    task automatic set_br(input logic [2:0] f, input logic z, input logic s,
                          input logic v, input logic c,
                          input logic [31:0] pc, input logic [31:0] imm);
        idle_in();
        valid_ex = 1'b1;
        branch   = 1'b1;
        funct3   = f;
        Zerof    = z;
        Sf       = s;
        Vf       = v;
        C        = c;
        pc_ex    = pc;
        imm_ex   = imm;
    endtask

    task automatic set_jal(input logic [31:0] pc, input logic [31:0] imm);
        idle_in();
        valid_ex = 1'b1;
        jal      = 1'b1;
        pc_ex    = pc;
        imm_ex   = imm;
    endtask

    task automatic set_jalr(input logic [31:0] a);
        idle_in();
        valid_ex = 1'b1;
        jalr     = 1'b1;
        alu_out  = a;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctl"}, ctl(), 32'd0);
        chk({tag, ".tgt"}, target, 32'd0);
        chk({tag, ".tot"}, br_total, 32'd0);
        chk({tag, ".tkn"}, br_taken, 32'd0);
    endtask

    // Apply current inputs across one edge and check the registered result
    task automatic step(input string tag, input logic et,
                        input logic [31:0] etg, input logic em,
                        input logic ei);
        logic cb;
        cb = !m_redir && valid_ex && !stall && branch && !jal && !jalr;
        @(posedge clk);
        #1;
        if (cb) begin
            m_tot = m_tot + 32'd1;
            if (et) m_tkn = m_tkn + 32'd1;
        end
        chk({tag, ".ctl"}, ctl(), {27'd0, et, et, et, em, ei});
        if (et) chk({tag, ".tgt"}, target, etg);
        chk({tag, ".tot"}, br_total, exp_tot());
        chk({tag, ".tkn"}, br_taken, exp_tkn());
        m_redir = et;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tg;
        logic [2:0]  kind;
        logic        ev;
        logic        t;
        logic        ill;

        m_redir = 1'b0;
        m_tot   = '0;
        m_tkn   = '0;
        rst     = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;

        set_br(3'b000, 1, 0, 0, 0, 32'h100, 32'h20);
        step("beq_t", 1, 32'h120, 0, 0);
        idle_in();
        step("beq_t_end", 0, 0, 0, 0);
        set_br(3'b000, 0, 0, 0, 0, 32'h100, 32'h20);
        step("beq_nt", 0, 0, 0, 0);

        set_br(3'b110, 0, 0, 0, 0, 32'h400, 32'hFFFF_FFF0);
        step("bltu_t", 1, 32'h3F0, 0, 0);
        idle_in();
        step("bltu_end", 0, 0, 0, 0);
        set_br(3'b111, 0, 0, 0, 0, 32'h400, 32'h10);
        step("bgeu_nt", 0, 0, 0, 0);
        set_br(3'b100, 0, 1, 1, 0, 32'h400, 32'h10);
        step("blt_nt", 0, 0, 0, 0);
        set_br(3'b101, 0, 0, 1, 0, 32'h400, 32'h10);
        step("bge_nt", 0, 0, 0, 0);

        set_jalr(32'h203);
        step("jalr_mis", 1, 32'h202, 1, 0);
        idle_in();
        step("jalr_end", 0, 0, 0, 0);
        set_jal(32'hFFFF_FFFC, 32'h8);
        step("jal_wrap", 1, 32'h4, 0, 0);
        idle_in();
        step("jal_end", 0, 0, 0, 0);

        set_br(3'b001, 0, 0, 0, 0, 32'h800, 32'h40);
        step("bne_t", 1, 32'h840, 0, 0);
        set_br(3'b000, 1, 0, 0, 0, 32'h900, 32'h40);
        step("b2b_ignored", 0, 0, 0, 0);
        idle_in();
        step("b2b_after", 0, 0, 0, 0);

        set_br(3'b000, 1, 0, 0, 0, 32'h1000, 32'h4);
        stall = 1'b1;
        step("stall_1", 0, 0, 0, 0);
        step("stall_2", 0, 0, 0, 0);
        stall = 1'b0;
        step("stall_rel", 1, 32'h1004, 0, 0);
        idle_in();
        step("stall_end", 0, 0, 0, 0);

        set_br(3'b010, 1, 1, 1, 1, 32'h10, 32'h10);
        step("rsvd_010", 0, 0, 0, 1);
        set_br(3'b011, 1, 1, 1, 1, 32'h10, 32'h10);
        step("rsvd_011", 0, 0, 0, 1);
        idle_in();
        step("rsvd_end", 0, 0, 0, 0);

`ifdef BRANCH_STATS_EN
        dut.tot_q = 32'hFFFF_FFFF;
        m_tot     = 32'hFFFF_FFFF;
        set_br(3'b000, 0, 0, 0, 0, 32'h20, 32'h20);
        step("tot_wrap", 0, 0, 0, 0);
`endif

        set_br(3'b000, 1, 0, 0, 0, 32'h2000, 32'h8);
        step("pre_rst", 1, 32'h2008, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        m_redir = 1'b0;
        m_tot   = '0;
        m_tkn   = '0;
        idle_in();
        rst = 1'b1;
        step("post_rst", 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            idle_in();
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
            flags_from(a, b);
            funct3   = 3'($urandom_range(0, 7));
            pc_ex    = $urandom;
            imm_ex   = $urandom;
            alu_out  = $urandom;
            valid_ex = ($urandom_range(0, 7) != 0);
            stall    = ($urandom_range(0, 7) == 0);
            kind     = 3'($urandom_range(0, 7));
            jalr     = kind[2];
            jal      = kind[1];
            branch   = kind[0];
            ev  = valid_ex && !stall && (kind != 3'd0);
            ill = 1'b0;
            if (jalr) begin
                t  = 1'b1;
                tg = alu_out & 32'hFFFF_FFFE;
            end else if (jal) begin
                t  = 1'b1;
                tg = pc_ex + imm_ex;
            end else begin
                t   = br_ref(funct3, a, b);
                tg  = pc_ex + imm_ex;
                ill = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            step("rand", ev && t, tg, ev && t && tg[1], ev && ill);
            if (ev && t) begin
                valid_ex = ($urandom_range(0, 1) == 1);
                stall    = ($urandom_range(0, 1) == 1);
                branch   = 1'b1;
                Zerof    = 1'b1;
                C        = 1'b1;
                funct3   = 3'($urandom_range(0, 7));
                step("rand_redir", 0, 0, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
